// File: rtl/hue_cycler.sv
// hue_cycler: colour-wheel hue walker driving three PWM duty levels.
// Hue advances one step per STEP_CYCLES enabled clocks, either direction.
module hue_cycler #(
   parameter int PWM_MAX       = 1200,
   parameter int STEPS_PER_SEG = 200,
   parameter int STEP_CYCLES   = 10000,
   parameter int PWM_DELTA     = PWM_MAX / STEPS_PER_SEG,
   parameter int HUE_STEPS     = 6 * STEPS_PER_SEG,
   localparam int PW = $clog2(PWM_MAX + 1),
   localparam int HW = $clog2(HUE_STEPS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          dir,
   input  logic          load,
   input  logic [HW-1:0] hue_in,
   output logic [PW-1:0] r_pwm,
   output logic [PW-1:0] g_pwm,
   output logic [PW-1:0] b_pwm,
   output logic [2:0]    seg,
   output logic          wrap
);

   localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int SW = $clog2(STEPS_PER_SEG);

   localparam logic [CW-1:0] PRE_MAX = CW'(STEP_CYCLES - 1);
   localparam logic [HW-1:0] H_MAX   = HW'(HUE_STEPS - 1);
   localparam logic [HW:0]   H_LIM   = (HW + 1)'(HUE_STEPS);
   localparam logic [SW-1:0] P_MAX   = SW'(STEPS_PER_SEG - 1);
   localparam logic [PW-1:0] MAX     = PW'(PWM_MAX);

   typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5} seg_e;

   seg_e          state_q, state_n;
   logic [HW-1:0] h_q, h_n, ldh;
   logic [SW-1:0] pos_q, pos_n;
   logic [CW-1:0] pre_q, pre_n;
   logic [PW-1:0] f, r_n, g_n, b_n;
   logic          tick, wrap_n;

   assign tick = en && (pre_q == PRE_MAX);
   assign ldh  = ({1'b0, hue_in} >= H_LIM) ? '0 : hue_in;
   assign seg  = state_q;

   always_comb begin
      pre_n = pre_q;
      if (load || tick)
         pre_n = '0;
      else if (en)
         pre_n = pre_q + CW'(1);
   end

   // Hue, segment and in-segment position move together; load re-derives all three.
   always_comb begin
      h_n     = h_q;
      pos_n   = pos_q;
      state_n = state_q;
      wrap_n  = 1'b0;
      if (load) begin
         h_n     = ldh;
         pos_n   = SW'(32'(ldh) % STEPS_PER_SEG);
         state_n = seg_e'(3'(32'(ldh) / STEPS_PER_SEG));
      end else if (tick && !dir) begin
         if (h_q == H_MAX) begin
            h_n    = '0;
            wrap_n = 1'b1;
         end else begin
            h_n = h_q + HW'(1);
         end
         if (pos_q == P_MAX) begin
            pos_n = '0;
            unique case (state_q)
               S0:      state_n = S1;
               S1:      state_n = S2;
               S2:      state_n = S3;
               S3:      state_n = S4;
               S4:      state_n = S5;
               default: state_n = S0;
            endcase
         end else begin
            pos_n = pos_q + SW'(1);
         end
      end else if (tick) begin
         if (h_q == '0) begin
            h_n    = H_MAX;
            wrap_n = 1'b1;
         end else begin
            h_n = h_q - HW'(1);
         end
         if (pos_q == '0) begin
            pos_n = P_MAX;
            unique case (state_q)
               S1:      state_n = S0;
               S2:      state_n = S1;
               S3:      state_n = S2;
               S4:      state_n = S3;
               S5:      state_n = S4;
               default: state_n = S5;
            endcase
         end else begin
            pos_n = pos_q - SW'(1);
         end
      end
   end

   assign f = PW'(32'(pos_n) * PWM_DELTA);

   always_comb begin
      r_n = MAX;
      g_n = '0;
      b_n = '0;
      unique case (state_n)
         S1: begin
            r_n = MAX - f;
            g_n = MAX;
         end
         S2: begin
            r_n = '0;
            g_n = MAX;
            b_n = f;
         end
         S3: begin
            r_n = '0;
            g_n = MAX - f;
            b_n = MAX;
         end
         S4: begin
            r_n = f;
            b_n = MAX;
         end
         S5: begin
            b_n = MAX - f;
            r_n = MAX;
         end
         default: g_n = f;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S0;
         h_q     <= '0;
         pos_q   <= '0;
         pre_q   <= '0;
         r_pwm   <= MAX;
         g_pwm   <= '0;
         b_pwm   <= '0;
         wrap    <= 1'b0;
      end else begin
         state_q <= state_n;
         h_q     <= h_n;
         pos_q   <= pos_n;
         pre_q   <= pre_n;
         r_pwm   <= r_n;
         g_pwm   <= g_n;
         b_pwm   <= b_n;
         wrap    <= wrap_n;
      end
   end

endmodule

// File: tb/tb_hue_cycler.sv
// Directed bench for hue_cycler with a small wheel (12 / 4 / 3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hue_cycler;

   logic       clk;
   logic       rst;
   logic       en;
   logic       dir;
   logic       load;
   logic [4:0] hue_in;
   logic [3:0] r_pwm, g_pwm, b_pwm;
   logic [2:0] seg;
   logic       wrap;

   int errors = 0;
   int checks = 0;

   hue_cycler #(
      .PWM_MAX(12),
      .STEPS_PER_SEG(4),
      .STEP_CYCLES(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .dir(dir),
      .load(load),
      .hue_in(hue_in),
      .r_pwm(r_pwm),
      .g_pwm(g_pwm),
      .b_pwm(b_pwm),
      .seg(seg),
      .wrap(wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int r, input int g,
                          input int b, input int s, input int w);
      check({tag, ".r"}, 32'(r_pwm), r);
      check({tag, ".g"}, 32'(g_pwm), g);
      check({tag, ".b"}, 32'(b_pwm), b);
      check({tag, ".seg"}, 32'(seg), s);
      check({tag, ".wrap"}, 32'(wrap), w);
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; dir = 1'b0; load = 1'b0; hue_in = '0;
      run(2);
      // forward revolution
      rst = 1'b0;
      #1 chk_out("fwd_rel", 12, 0, 0, 0, 0);
      run(3);  chk_out("fwd_c3", 12, 3, 0, 0, 0);
      run(9);  chk_out("fwd_c12", 12, 12, 0, 1, 0);
      run(59); chk_out("fwd_c71", 12, 0, 3, 5, 0);
      run(1);  chk_out("fwd_c72", 12, 0, 0, 0, 1);
      run(1);  check("fwd_c73.wrap", 32'(wrap), 0);

      // reverse from reset
      rst = 1'b1; dir = 1'b1;
      run(1);
      rst = 1'b0;
      #1 chk_out("rev_rel", 12, 0, 0, 0, 0);
      run(2);  chk_out("rev_c2", 12, 0, 0, 0, 0);
      run(1);  chk_out("rev_c3", 12, 0, 3, 5, 1);
      run(1);  check("rev_c4.wrap", 32'(wrap), 0);

      // enable freeze
      rst = 1'b1; dir = 1'b0;
      run(1);
      rst = 1'b0;
      run(4);  chk_out("en_pre1", 12, 3, 0, 0, 0);
      en = 1'b0;
      run(10); chk_out("en_frozen", 12, 3, 0, 0, 0);
      en = 1'b1;
      run(1);  chk_out("en_re1", 12, 3, 0, 0, 0);
      run(1);  chk_out("en_re2", 12, 6, 0, 0, 0);

      // load and load-vs-tick
      load = 1'b1; hue_in = 5'd10;
      run(1);  chk_out("ld10", 0, 12, 6, 2, 0);
      load = 1'b0;
      run(2);  chk_out("ld10_c2", 0, 12, 6, 2, 0);
      run(1);  chk_out("ld10_c3", 0, 12, 9, 2, 0);
      load = 1'b1; hue_in = 5'd23;
      run(1);  chk_out("ld23", 12, 0, 3, 5, 0);
      load = 1'b0;
      run(2);
      load = 1'b1; hue_in = 5'd10;
      run(1);  chk_out("ld_vs_tick", 0, 12, 6, 2, 0);
      load = 1'b0;
      run(2);  chk_out("ld_pre0", 0, 12, 6, 2, 0);
      run(1);  chk_out("ld_step", 0, 12, 9, 2, 0);

      // out-of-range load with en low
      en = 1'b0; load = 1'b1; hue_in = 5'd30;
      run(1);  chk_out("ld30", 12, 0, 0, 0, 0);
      load = 1'b0; en = 1'b1;

      // asynchronous reset mid segment 3
      load = 1'b1; hue_in = 5'd14;
      run(1);  chk_out("ld14", 0, 6, 12, 3, 0);
      load = 1'b0;
      run(1);
      #2 rst = 1'b1;
      #1 chk_out("async_rst", 12, 0, 0, 0, 0);
      run(1);
      rst = 1'b0;
      run(2);  chk_out("rst_c2", 12, 0, 0, 0, 0);
      run(1);  chk_out("rst_c3", 12, 3, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
